button_input: RTL

//   Input-side front end for the board push-buttons: turns the two raw, bouncing,

---
 rtl/button_pkg.sv | 9 +
 rtl/button_input_debounce_channel.sv | 57 +++++
 rtl/button_input.sv | 61 ++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button front end.
package button_pkg;

    typedef enum logic {MODE_UP = 1'b0, MODE_DOWN = 1'b1} mode_e;

    // 10 ms at the 27 MHz board clock.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 270000;

endpackage

// File: rtl/button_input_debounce_channel.sv
// One button channel: 2-flop synchroniser, polarity normalisation,
// stability counter and single-cycle press/release pulses.
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic press,
    output logic rel        // "release" is a reserved word in SystemVerilog
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic           IDLE_PIN = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic          sync1;
    logic          sync2;
    logic          p;
    logic [CW-1:0] cnt;

    // p = 1 means pressed, whatever the pin polarity.
    assign p = sync2 ^ IDLE_PIN;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the synchroniser resets to the released pin value so a button
            // held through reset is re-qualified instead of seen as an instant press.
            sync1 <= IDLE_PIN;
            sync2 <= IDLE_PIN;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every flop
            // samples the pre-edge values; blocking would collapse the sync chain.
            sync1 <= pin;
            sync2 <= sync1;
            press <= 1'b0;
            rel   <= 1'b0;
            if (p == level) begin
                cnt <= '0;
            end else if (cnt >= CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
                press <= ~level;
                rel   <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_input.sv
// Push-button front end: two debounced channels plus the count-direction
// mode register (btn1 selects up, btn2 selects down).
module button_input
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn1,
    input  logic btn2,
    output logic btn1_level,
    output logic btn2_level,
    output logic btn1_press,
    output logic btn2_press,
    output logic btn1_release,
    output logic btn2_release,
    output logic mode
);

    mode_e mode_q;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch1 (
        .clk   (clk),
        .rst   (rst),
        .pin   (btn1),
        .level (btn1_level),
        .press (btn1_press),
        .rel   (btn1_release)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch2 (
        .clk   (clk),
        .rst   (rst),
        .pin   (btn2),
        .level (btn2_level),
        .press (btn2_press),
        .rel   (btn2_release)
    );

    // Simultaneous presses are ambiguous, so they leave the mode alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_UP;
        end else if (btn1_press && !btn2_press) begin
            mode_q <= MODE_UP;
        end else if (btn2_press && !btn1_press) begin
            mode_q <= MODE_DOWN;
        end
    end

    assign mode = mode_q;

endmodule
